// File: rtl/decode_sequencer.sv
// M6502 instruction sequencer: one-hot timing register, instruction register and enable decode.
// Define DECODE_ILLEGAL_TRAP_EN to halt at T2 on an illegal opcode instead of running it as a NOP.
//
// state | meaning
// T1    | opcode fetch, no enables
// T2    | first decode cycle; two-cycle instructions finish here
// T3    | JMP finishes; absolute loads/stores fetch the operand address
// T4    | absolute load/store memory access
// Tn    | last state; reaching it without TIMING_RESET trips the watchdog
module decode_sequencer #(
    parameter int TIMING_STATES = 8,
    parameter int ENABLE_WIDTH  = 32
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     ready,
    input  logic [7:0]               data_in,
    output logic [TIMING_STATES-1:0] timing,
    output logic [7:0]               opcode,
    output logic                     sync,
    output logic [ENABLE_WIDTH-1:0]  enables,
    output logic                     seq_error,
    output logic                     halted
);

    localparam logic [TIMING_STATES-1:0] T1 = TIMING_STATES'(1);

    localparam int ADDR_RP      = 0;
    localparam int DATA_OUT_RA  = 1;
    localparam int PC_HOLD      = 2;
    localparam int PC_OPERAND   = 3;
    localparam int RA_OPERAND   = 4;
    localparam int RP_OPERAND   = 5;
    localparam int RX_OPERAND   = 6;
    localparam int RY_OPERAND   = 7;
    localparam int TIMING_RESET = 8;
    localparam int WRITE_EN     = 9;
    localparam int DATA_OUT_RX  = 10;
    localparam int DATA_OUT_RY  = 11;
    localparam int RX_FROM_RA   = 12;
    localparam int RY_FROM_RA   = 13;
    localparam int RX_INC       = 14;
    localparam int RY_INC       = 15;
    localparam int ILLEGAL      = 16;

    logic [TIMING_STATES-1:0] timing_q;
    logic [7:0]               opcode_q;
    logic                     seq_error_q;
    logic [16:0]              dec;

    always_comb begin
        dec = '0;
        if (timing_q[1]) begin
            case (opcode_q)
                8'hEA: dec[TIMING_RESET] = 1'b1;
                8'hAA: begin dec[RX_FROM_RA] = 1'b1; dec[TIMING_RESET] = 1'b1; end
                8'hA8: begin dec[RY_FROM_RA] = 1'b1; dec[TIMING_RESET] = 1'b1; end
                8'hE8: begin dec[RX_INC]     = 1'b1; dec[TIMING_RESET] = 1'b1; end
                8'hC8: begin dec[RY_INC]     = 1'b1; dec[TIMING_RESET] = 1'b1; end
                8'hA9: begin dec[RA_OPERAND] = 1'b1; dec[TIMING_RESET] = 1'b1; end
                8'hA2: begin dec[RX_OPERAND] = 1'b1; dec[TIMING_RESET] = 1'b1; end
                8'hA0: begin dec[RY_OPERAND] = 1'b1; dec[TIMING_RESET] = 1'b1; end
                8'h4C, 8'hAD, 8'hAE, 8'hAC, 8'h8D, 8'h8E, 8'h8C: dec = '0;
                default: begin
                    dec[ILLEGAL] = 1'b1;
`ifdef DECODE_ILLEGAL_TRAP_EN
                    dec[PC_HOLD] = 1'b1;
`else
                    dec[TIMING_RESET] = 1'b1;
`endif
                end
            endcase
        end else if (timing_q[2]) begin
            case (opcode_q)
                8'h4C: begin dec[PC_OPERAND] = 1'b1; dec[TIMING_RESET] = 1'b1; end
                8'hAD, 8'hAE, 8'hAC, 8'h8D, 8'h8E, 8'h8C: dec[RP_OPERAND] = 1'b1;
                default: dec = '0;
            endcase
        end else if (timing_q[3]) begin
            case (opcode_q)
                8'hAD: dec[RA_OPERAND]  = 1'b1;
                8'hAE: dec[RX_OPERAND]  = 1'b1;
                8'hAC: dec[RY_OPERAND]  = 1'b1;
                8'h8D: begin dec[WRITE_EN] = 1'b1; dec[DATA_OUT_RA] = 1'b1; end
                8'h8E: begin dec[WRITE_EN] = 1'b1; dec[DATA_OUT_RX] = 1'b1; end
                8'h8C: begin dec[WRITE_EN] = 1'b1; dec[DATA_OUT_RY] = 1'b1; end
                default: dec = '0;
            endcase
            // Common memory-access controls for every absolute load/store.
            case (opcode_q)
                8'hAD, 8'hAE, 8'hAC, 8'h8D, 8'h8E, 8'h8C: begin
                    dec[ADDR_RP]      = 1'b1;
                    dec[PC_HOLD]      = 1'b1;
                    dec[TIMING_RESET] = 1'b1;
                end
                default: ;
            endcase
        end
        if (!ready) begin
            dec          = '0;
            dec[PC_HOLD] = 1'b1;
        end
    end

`ifdef DECODE_ILLEGAL_TRAP_EN
    logic is_illegal;

    always_comb begin
        case (opcode_q)
            8'hEA, 8'hAA, 8'hA8, 8'hE8, 8'hC8, 8'hA9, 8'hA2, 8'hA0,
            8'h4C, 8'hAD, 8'hAE, 8'hAC, 8'h8D, 8'h8E, 8'h8C: is_illegal = 1'b0;
            default:                                          is_illegal = 1'b1;
        endcase
    end

    // Timing freezes at T2 and the opcode cannot reload, so this holds until reset.
    assign halted = timing_q[1] & is_illegal;
`else
    assign halted = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            timing_q    <= T1;
            opcode_q    <= 8'hEA;
            seq_error_q <= 1'b0;
        end else if (ready) begin
            if (timing_q[0])
                opcode_q <= data_in;
            if (halted)
                timing_q <= timing_q;
            else if (dec[TIMING_RESET])
                timing_q <= T1;
            else if (timing_q[TIMING_STATES-1]) begin
                timing_q    <= T1;
                seq_error_q <= 1'b1;
            end else
                timing_q <= {timing_q[TIMING_STATES-2:0], 1'b0};
        end
    end

    always_comb begin
        enables       = '0;
        enables[16:0] = dec;
    end

    assign timing    = timing_q;
    assign opcode    = opcode_q;
    assign sync      = timing_q[0];
    assign seq_error = seq_error_q;

endmodule

// File: doc/decode_sequencer.md
# decode_sequencer

Instruction sequencer for the M6502 core. It owns the one-hot timing-state register and the instruction register, and it turns (timing, opcode) into the datapath enable word. The decode covers immediate, absolute, transfer and increment instructions, and adds a stall input, a sticky sequencing-error flag and optional illegal-opcode trapping. It sits between the memory data bus and the register/PC/address datapath.

## Interface
Parameters:
- TIMING_STATES, 8: width of the one-hot timing vector, T1..Tn. Minimum 5.
- ENABLE_WIDTH, 32: width of the enables word. Minimum 17; bits 17 and up are always 0.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  reset; synchronous, active-high.
- ready  in  1  1 = advance; 0 = stall in the current state.
- data_in  in  8  memory read data; holds the opcode during T1.
- timing  out  TIMING_STATES  one-hot current state; bit0 = T1.
- opcode  out  8  instruction register.
- sync  out  1  equals timing[0]; marks the opcode fetch cycle.
- enables  out  ENABLE_WIDTH  decoded controls, combinational from timing, opcode and ready.
- seq_error  out  1  sticky; set when the last timing state is reached without TIMING_RESET.
- halted  out  1  illegal-opcode trap state; active only when DECODE_ILLEGAL_TRAP_EN is defined.

Enable bit indices:
- 0 ADDR_RP, 1 DATA_OUT_RA, 2 PC_HOLD, 3 PC_OPERAND
- 4 RA_OPERAND, 5 RP_OPERAND, 6 RX_OPERAND, 7 RY_OPERAND
- 8 TIMING_RESET, 9 WRITE_EN, 10 DATA_OUT_RX, 11 DATA_OUT_RY
- 12 RX_FROM_RA, 13 RY_FROM_RA, 14 RX_INC, 15 RY_INC, 16 ILLEGAL

## Operation
- T1 is the fetch cycle. All enables are 0 in T1. The opcode register loads data_in at the end of T1 when ready=1.
- Decode runs in T2 and later, always from the registered opcode.
- Each instruction's final cycle asserts TIMING_RESET, which sends the next state to T1. Otherwise the one-hot state shifts left one position.
- Two-cycle instructions (all assert TIMING_RESET in T2):
  - NOP EA: no other enables.
  - TAX AA: RX_FROM_RA.
  - TAY A8: RY_FROM_RA.
  - INX E8: RX_INC.
  - INY C8: RY_INC.
  - LDA/LDX/LDY immediate A9/A2/A0: RA/RX/RY_OPERAND respectively.
- JMP abs 4C:
  - T2: no enables.
  - T3: PC_OPERAND, TIMING_RESET.
- Loads, absolute (LDA AD, LDX AE, LDY AC):
  - T2: no enables.
  - T3: RP_OPERAND.
  - T4: ADDR_RP, PC_HOLD, the matching R*_OPERAND, TIMING_RESET.
- Stores, absolute (STA 8D, STX 8E, STY 8C):
  - T2: no enables.
  - T3: RP_OPERAND.
  - T4: ADDR_RP, PC_HOLD, WRITE_EN, the matching DATA_OUT_R*, TIMING_RESET.
- Any other opcode is illegal. In T2 it asserts ILLEGAL and TIMING_RESET; the trap variant is described under Configuration.
- When ready=0:
  - timing, opcode and seq_error hold.
  - enables is forced to exactly PC_HOLD, even during T1.
- Watchdog: if the state is T(TIMING_STATES) with ready=1 and TIMING_RESET is not asserted, the next state is T1 and seq_error is set. Only reset clears seq_error. With the shipped opcode table this path is unreachable except through a fault.

## Timing
- Reset values, one cycle after reset is asserted:
  - timing = 1 (T1), opcode = 8'hEA, sync = 1.
  - seq_error = 0, halted = 0.
  - enables = 0, or PC_HOLD alone if ready=0.
- Reset asserted mid-instruction abandons the instruction. No WRITE_EN is asserted in the cycle after reset.
- Reset has priority over ready, the watchdog and the trap.
- Enables have zero latency relative to the state: they are valid in the same cycle as timing.
- Instruction lengths in clocks, with ready held high:
  - NOP / transfer / increment / immediate: 2.
  - JMP: 3.
  - Absolute load or store: 4.
- Every stalled cycle adds exactly one clock.
- Back-to-back instructions: the cycle after TIMING_RESET is T1 of the next instruction, with no bubble.

## Configuration
- DECODE_ILLEGAL_TRAP_EN defined:
  - An illegal opcode in T2 asserts ILLEGAL and PC_HOLD but not TIMING_RESET.
  - halted is set, timing freezes at T2, and ILLEGAL and PC_HOLD stay asserted until reset.
  - The watchdog does not fire while halted.
- DECODE_ILLEGAL_TRAP_EN undefined:
  - An illegal opcode executes as a 2-cycle NOP that additionally pulses ILLEGAL in T2.
  - halted is tied to 0.

## Test plan
- Reset, then feed A9 in T1 with ready=1 -> T2 has enables = 0x0110 (RA_OPERAND | TIMING_RESET); the next cycle has timing = 1.
- Feed 8E (STX abs) -> T3 enables = 0x0020; T4 enables = 0x0705 (ADDR_RP | PC_HOLD | TIMING_RESET | WRITE_EN | DATA_OUT_RX); total 4 clocks.
- Start LDA AD and hold ready=0 for 2 cycles in T3 -> timing stays at 0x04, enables = 0x0004 during the stall; the instruction takes 6 clocks in total.
- Feed illegal opcode 02:
  - Trap build: from T2 onward halted = 1, timing = 0x02 and enables = 0x10004 persist until reset; after reset, timing = 1 and halted = 0.
  - Non-trap build: T2 enables = 0x10100, then T1.
- Assert reset during T3 of STA abs -> the next cycle has timing = 1, opcode = EA, enables = 0, and WRITE_EN is never asserted.
- Force the opcode register to an unterminated value via a bench override with TIMING_STATES=5 -> after T5 the next state is T1 and seq_error = 1, remaining 1 until reset.
